// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes, iterative shifts and Z/C/N/ERR flags.
// Define SEQ_ALU_MUL_EN to build in the iterative shift-add multiplier (funct 7).
module seq_alu #(
  parameter int unsigned DW   = 8,
  parameter int unsigned IMMW = 6,
  parameter int unsigned SW   = $clog2(DW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      funct,
  input  logic [DW-1:0]   rs1_data,
  input  logic [DW-1:0]   rd_data,
  input  logic [IMMW-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_n,
  output logic            flag_err
);

  // Counter must hold DW itself for the multiplier iteration count.
  localparam int unsigned CW = SW + 1;

  typedef enum logic [1:0] {StIdle, StShift, StMul, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          sc_q, sc_d;
  logic [DW-1:0] out_q, out_d;
  logic          fz_q, fz_d, fc_q, fc_d, fn_q, fn_d, ferr_q, ferr_d;
`ifdef SEQ_ALU_MUL_EN
  logic [DW-1:0]   b_q, b_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW:0]     psum;
  logic            is_mul;
`endif

  logic [DW:0]    add_w, sub_w;
  logic [DW-1:0]  imm_ext, res_val, fin_val;
  logic [SW-1:0]  shamt;
  logic           res_c, res_err, is_shift;
  logic           accept, fin_en, fin_c, fin_err;

  always_comb begin
    add_w    = {1'b0, rs1_data} + {1'b0, rd_data};
    sub_w    = {1'b0, rs1_data} - {1'b0, rd_data};
    imm_ext  = '0;
    imm_ext[IMMW-1:0] = imm;
    shamt    = rd_data[SW-1:0];
    res_val  = '0;
    res_c    = 1'b0;
    res_err  = 1'b0;
    is_shift = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    is_mul   = 1'b0;
`endif
    unique case (funct)
      4'd0: begin res_val = add_w[DW-1:0]; res_c = add_w[DW]; end
      4'd1: res_val = rs1_data & rd_data;
      4'd2: res_val = rs1_data | rd_data;
      4'd3: res_val = rs1_data ^ rd_data;
      4'd4: begin res_val = sub_w[DW-1:0]; res_c = sub_w[DW]; end
      // Shift by zero completes here with the operand unchanged.
      4'd5, 4'd6: begin res_val = rs1_data; is_shift = 1'b1; end
`ifdef SEQ_ALU_MUL_EN
      4'd7: is_mul = 1'b1;
`endif
      4'd8: begin res_c = (rs1_data == rd_data); res_val = res_c ? imm_ext : DW'(1); end
      4'd9: begin res_c = (rs1_data < rd_data); res_val = res_c ? imm_ext : DW'(1); end
      4'd10: begin res_c = (rs1_data != rd_data); res_val = res_c ? imm_ext : DW'(1); end
      default: res_err = 1'b1;
    endcase
  end

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    sc_d    = sc_q;
    fin_en  = 1'b0;
    fin_val = '0;
    fin_c   = 1'b0;
    fin_err = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    b_d     = b_q;
    acc_d   = acc_q;
    psum    = {1'b0, acc_q[2*DW-1:DW]} + (b_q[0] ? {1'b0, a_q} : '0);
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) state_d = StIdle;
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_d = StShift;
            a_d     = rs1_data;
            cnt_d   = CW'(shamt);
            dir_d   = (funct == 4'd6);
            sc_d    = 1'b0;
          end
`ifdef SEQ_ALU_MUL_EN
          else if (is_mul) begin
            state_d = StMul;
            a_d     = rs1_data;
            b_d     = rd_data;
            cnt_d   = CW'(DW);
            acc_d   = '0;
          end
`endif
          else begin
            state_d = StDone;
            fin_en  = 1'b1;
            fin_val = res_val;
            fin_c   = res_c;
            fin_err = res_err;
          end
        end
      end
      StShift: begin
        cnt_d = cnt_q - 1'b1;
        if (dir_q) begin
          sc_d = a_q[0];
          a_d  = a_q >> 1;
        end else begin
          sc_d = a_q[DW-1];
          a_d  = a_q << 1;
        end
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          fin_en  = 1'b1;
          fin_val = a_d;
          fin_c   = sc_d;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      StMul: begin
        // Add the multiplicand into the high half, then shift the accumulator right.
        cnt_d = cnt_q - 1'b1;
        acc_d = {psum, acc_q[DW-1:1]};
        b_d   = b_q >> 1;
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          fin_en  = 1'b1;
          fin_val = acc_d[DW-1:0];
          fin_c   = |acc_d[2*DW-1:DW];
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    out_d  = out_q;
    fz_d   = fz_q;
    fc_d   = fc_q;
    fn_d   = fn_q;
    ferr_d = ferr_q;
    if (fin_en) begin
      out_d  = fin_val;
      fz_d   = (fin_val == '0);
      fc_d   = fin_c;
      fn_d   = fin_val[DW-1];
      ferr_d = fin_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sc_q    <= 1'b0;
      out_q   <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fn_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      b_q     <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sc_q    <= sc_d;
      out_q   <= out_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      fn_q    <= fn_d;
      ferr_q  <= ferr_d;
`ifdef SEQ_ALU_MUL_EN
      b_q     <= b_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign out      = out_q;
  assign flag_z   = fz_q;
  assign flag_c   = fc_q;
  assign flag_n   = fn_q;
  assign flag_err = ferr_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (DW = 8): expectations queued on accept, checked on output.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] funct;
  logic [7:0] rs1_data, rd_data, out;
  logic [5:0] imm;
  logic       flag_z, flag_c, flag_n, flag_err;

  typedef struct {
    logic [7:0] val;
    logic       z, c, n, err;
    int         lat;
    int         k;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   lat_seen = 1'b0;
  bit   rand_bp = 1'b0;

  seq_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct    (funct),
    .rs1_data (rs1_data),
    .rd_data  (rd_data),
    .imm      (imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_n   (flag_n),
    .flag_err (flag_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                                 input logic [5:0] im);
    exp_t        e;
    logic [15:0] w;
    int          s;
    e.val = 8'h00; e.c = 1'b0; e.err = 1'b0; e.lat = 1; e.k = 0;
    s = int'(b[2:0]);
    case (f)
      4'd0: begin w = a + b; e.val = w[7:0]; e.c = w[8]; end
      4'd1: e.val = a & b;
      4'd2: e.val = a | b;
      4'd3: e.val = a ^ b;
      4'd4: begin e.val = a - b; e.c = (a < b); end
      4'd5: begin e.val = a << s; e.c = (s == 0) ? 1'b0 : a[8-s]; e.lat = s + 1; end
      4'd6: begin e.val = a >> s; e.c = (s == 0) ? 1'b0 : a[s-1]; e.lat = s + 1; end
`ifdef SEQ_ALU_MUL_EN
      4'd7: begin w = a * b; e.val = w[7:0]; e.c = (w[15:8] != 8'h00); e.lat = 9; end
`endif
      4'd8: begin e.c = (a == b); e.val = e.c ? {2'b00, im} : 8'h01; end
      4'd9: begin e.c = (a < b); e.val = e.c ? {2'b00, im} : 8'h01; end
      4'd10: begin e.c = (a != b); e.val = e.c ? {2'b00, im} : 8'h01; end
      default: e.err = 1'b1;
    endcase
    e.z = (e.val == 8'h00);
    e.n = e.val[7];
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] im);
    exp_t e;
    int   n;
    funct = f; rs1_data = a; rd_data = b; imm = im; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = model(f, a, b, im);
        e.k = cyc;
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t h;
    if (!rst_n) begin
      lat_seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        if (!lat_seen) begin
          check("latency", cyc - sb[0].k, sb[0].lat);
          lat_seen = 1'b1;
        end
        if (out_ready) begin
          h = sb.pop_front();
          check("out", out, h.val);
          check("flag_z", flag_z, h.z);
          check("flag_c", flag_c, h.c);
          check("flag_n", flag_n, h.n);
          check("flag_err", flag_err, h.err);
          lat_seen = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct = '0; rs1_data = '0; rd_data = '0; imm = '0;
    repeat (2) @(negedge clk);
    check("rst_out", {out, flag_z, flag_c, flag_n, flag_err}, 12'h000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, back to back with out_ready high.
    issue(4'd0, 8'hF0, 8'h20, 6'h00);
    issue(4'd5, 8'h81, 8'h03, 6'h00);
    issue(4'd5, 8'h81, 8'h08, 6'h00);
    issue(4'd6, 8'h81, 8'h07, 6'h00);
    issue(4'd7, 8'h0F, 8'h11, 6'h00);
    issue(4'd7, 8'h10, 8'h10, 6'h00);
    issue(4'd8, 8'h33, 8'h33, 6'h2A);
    issue(4'd9, 8'h05, 8'h04, 6'h15);
    issue(4'd10, 8'h05, 8'h04, 6'h3F);
    issue(4'd12, 8'hAA, 8'h55, 6'h00);
    issue(4'd4, 8'h04, 8'h05, 6'h00);
    issue(4'd1, 8'h3C, 8'h0F, 6'h00);
    drain();

    // Random ops under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 6'($urandom));
    end
    drain();
    rand_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Held result under backpressure, with a pending op accepted on release.
    out_ready = 1'b0;
    issue(4'd0, 8'hF0, 8'h20, 6'h00);
    check("bp_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    fork
      issue(4'd3, 8'h3C, 8'h0F, 6'h00);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_out", out, 8'h10);
          check("bp_flags", {flag_z, flag_c, flag_n, flag_err}, 4'b0100);
          check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1'b1);
      end
    join
    drain();

    // Reset in the middle of a long operation.
`ifdef SEQ_ALU_MUL_EN
    issue(4'd7, 8'h0F, 8'h11, 6'h00);
`else
    issue(4'd5, 8'h81, 8'h07, 6'h00);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out", {out, flag_z, flag_c, flag_n, flag_err}, 12'h000);
    check("mid_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    repeat (12) begin
      @(negedge clk);
      check("no_stale", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    issue(4'd2, 8'h50, 8'h05, 6'h00);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the core's combinational ALU. It executes one operation at a time: the register-register ops and branch compares of the original in a single cycle, plus iterative shifts and an optional iterative multiplier. It adds Z/C/N/ERR flags and valid/ready handshakes on both input and output. It sits between the decode stage and writeback/PC-update, and it stalls decode through `in_ready`.

## Interface
- `DW`, 8: datapath width in bits; must be ≥ 4 and a power of two.
- `IMMW`, 6: branch immediate width in bits; must be ≤ DW.
- `SW`, $clog2(DW): width of the shift-amount field.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the block accepts this cycle.
- `funct` in 4: operation code (see Operation).
- `rs1_data` in DW: operand A.
- `rd_data` in DW: operand B. Shift ops use only `rd_data[SW-1:0]`, as the shift amount.
- `imm` in IMMW: branch target offset.
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: the consumer takes the result.
- `out` out DW: result.
- `flag_z`, `flag_c`, `flag_n`, `flag_err` out 1 each: zero, carry/borrow, sign (`out[DW-1]`), illegal funct.

## Operation
- Transfers: an input transfer occurs when `in_valid & in_ready`. An output transfer occurs when `out_valid & out_ready`.
- Funct codes:
  - 0 ADD: C = carry-out.
  - 1 AND, 2 OR, 3 XOR: C = 0.
  - 4 SUB: A-B, C = borrow (A < B unsigned).
  - 5 SLL, 6 SRL: shift A by s = `rd_data[SW-1:0]`; C = last bit shifted out, or 0 when s = 0.
  - 7 MUL: low DW bits of A*B; C = 1 iff the high DW bits are non-zero.
  - 8 BEQ, 9 BLT (unsigned), 10 BNE: out = condition ? zero-extended `imm` : 1; C = condition.
  - 11–15: illegal.
- Illegal funct: out = 0, flag_err = 1, Z = 1, single-cycle latency.
- Flags: Z = (out == 0) for every op. N = `out[DW-1]` for every op. Flags are registered together with `out`.
- Operands and funct are captured on acceptance. Inputs are ignored while the block is busy.
- FSM states:
  - IDLE → DONE on accepting a single-cycle op, or a shift with s = 0.
  - IDLE → SHIFT on accepting a shift with s > 0.
  - IDLE → MUL on accepting MUL.
  - SHIFT: shift 1 bit per cycle and decrement the count. On the last bit, go to DONE.
  - MUL: shift-add, 1 multiplier bit per cycle, LSB first, with a 2·DW-bit accumulator. After DW iterations, go to DONE.
  - DONE: `out_valid` = 1, outputs held stable. On an output transfer, go to IDLE, or straight back into a new op if one is accepted that cycle.
- `in_ready` = (state == IDLE) | (state == DONE & out_ready).
- Reset (asynchronous, any time, including mid-SHIFT or mid-MUL): state goes to IDLE, the operation in flight is discarded, and `out`, all flags and `out_valid` go to 0.
- After reset release: `in_ready` = 1 and `out_valid` = 0.

## Timing
- Accepted at edge k:
  - Single-cycle ops, illegal funct, and shifts with s = 0: `out_valid` high after edge k+1.
  - Shifts with s > 0: `out_valid` high after edge k+1+s.
  - MUL: `out_valid` high after edge k+1+DW.
- Throughput:
  - With `out_ready` tied high, single-cycle ops sustain 1 op/cycle through the DONE-to-accept path.
  - Multi-cycle ops occupy the block for their full latency.
- Backpressure: while in DONE with `out_ready` = 0, `out` and the flags are held, `in_ready` = 0, and nothing new is accepted.
- All outputs are registered. `in_ready` is the only output with a combinational path, from `out_ready`.

## Configuration
- `SEQ_ALU_MUL_EN` defined: the MUL state, the accumulator and funct 7 are compiled in.
- `SEQ_ALU_MUL_EN` undefined: funct 7 is treated as illegal (out = 0, flag_err = 1, single-cycle latency). No multiplier logic is present.

## Test plan
- ADD, A = 0xF0, B = 0x20, DW = 8 → out = 0x10, C = 1, Z = 0, N = 0, `out_valid` 1 cycle after accept.
- SLL, A = 0x81, s = 3 → out = 0x08, C = 0, `out_valid` 4 cycles after accept. Then s = 0 → out = A, C = 0, latency 1.
- MUL (macro defined), 0x0F*0x11 → out = 0xFF, C = 0, latency 9. Then 0x10*0x10 → out = 0x00, Z = 1, C = 1. Same MUL with the macro undefined → flag_err = 1, out = 0.
- BEQ, A = B = 0x33, imm = 0x2A → out = 0x2A, C = 1. BLT, A = 0x05, B = 0x04 → out = 0x01, C = 0. Funct 12 → flag_err = 1.
- Hold `out_ready` low 5 cycles after an ADD result → `out` and flags stable, `in_ready` = 0, a pending input is not accepted. Raise `out_ready` → result drained and the pending op accepted the same cycle.
- Assert `rst_n` low for 1 cycle, 3 cycles into a MUL → all outputs 0, `in_ready` = 1 after release, no stale result appears.
